// File: rtl/mario_token_collector_if.sv
// ----------------------------------------------------------------------------
// mario_token_collector_if
// Tile write channel from the token collector to the background store.
//   wr_valid : write request, held until accepted
//   wr_ready : store accepts the write this cycle
//   wr_row   : tile row to overwrite
//   wr_col   : tile column to overwrite
//   wr_data  : tile code to write
// master = collector side, slave = background store side.
// ----------------------------------------------------------------------------
interface mario_token_collector_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_row;
    logic [4:0] wr_col;
    logic [7:0] wr_data;

    modport master (
        output wr_valid,
        output wr_row,
        output wr_col,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_row,
        input  wr_col,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/mario_token_collector.sv
// ----------------------------------------------------------------------------
// mario_token_collector
// Once per frame tick, latches Mario's bounding box as a tile range, scans the
// range row-major one tile per cycle and requests a TKN->SKY overwrite for
// every token found. Keeps a 16-bit collected-token score.
//
// Ports:
//   vga_clock  : sole clock
//   reset      : synchronous, active-high
//   tick       : one-cycle frame start pulse (ignored while busy)
//   mario_x/y  : Mario top-left corner in pixels (signed)
//   background : current tile map, [row][col] of 8-bit tile codes
//   wr         : tile write channel (master side)
//   busy       : scan in progress (SCAN, WRITE, DONE)
//   collect    : one-cycle pulse per accepted write
//   score      : tokens collected
//
// Build option:
//   MARIO_TOKEN_SCORE_SATURATE_EN : when defined, score saturates at 16'hFFFF;
//                                   otherwise it wraps to 0.
// ----------------------------------------------------------------------------
module mario_token_collector #(
    parameter int SKY          = 1,
    parameter int TKN          = 4,
    parameter int MARIO_WIDTH  = 42,
    parameter int MARIO_HEIGHT = 40,
    parameter int BLOCK_WIDTH  = 40,
    parameter int ROWS         = 12,
    parameter int COLS         = 17
) (
    input  logic                           vga_clock,
    input  logic                           reset,
    input  logic                           tick,
    input  logic signed [31:0]             mario_x,
    input  logic signed [31:0]             mario_y,
    input  logic [ROWS-1:0][COLS-1:0][7:0] background,
    mario_token_collector_if.master        wr,
    output logic                           busy,
    output logic                           collect,
    output logic [15:0]                    score
);

    localparam int unsigned ROW_W   = 4;
    localparam int unsigned COL_W   = 5;
    localparam int unsigned POS_W   = 34;
    localparam int unsigned SCORE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Pixel edge to tile index: negative edges clamp to 0, large ones to lim-1.
    function automatic logic [COL_W-1:0] tile_of(input logic signed [POS_W-1:0] px,
                                                 input int unsigned lim);
        logic [POS_W-1:0] q;
        if (px < 0) begin
            q = '0;
        end else begin
            q = $unsigned(px) / POS_W'(BLOCK_WIDTH);
        end
        if (q > POS_W'(lim - 1)) begin
            q = POS_W'(lim - 1);
        end
        return COL_W'(q);
    endfunction

    state_t             state_q, state_n;
    logic [ROW_W-1:0]   row_q, row_n;
    logic [COL_W-1:0]   col_q, col_n;
    logic [COL_W-1:0]   c0_q, c0_n;
    logic [COL_W-1:0]   c1_q, c1_n;
    logic [ROW_W-1:0]   r1_q, r1_n;
    logic [ROW_W-1:0]   wr_row_q, wr_row_n;
    logic [COL_W-1:0]   wr_col_q, wr_col_n;
    logic               wr_valid_q;
    logic [7:0]         wr_data_q;
    logic               busy_q;
    logic               collect_q, collect_n;
    logic [SCORE_W-1:0] score_q, score_n;

    // Tile range of the current position, used only when a tick is accepted.
    logic signed [POS_W-1:0] x_lo, x_hi, y_lo, y_hi;
    logic [COL_W-1:0]        rng_c0, rng_c1;
    logic [ROW_W-1:0]        rng_r0, rng_r1;

    always_comb begin
        x_lo   = POS_W'(mario_x);
        y_lo   = POS_W'(mario_y);
        x_hi   = x_lo + POS_W'(MARIO_WIDTH - 1);
        y_hi   = y_lo + POS_W'(MARIO_HEIGHT - 1);
        rng_c0 = tile_of(x_lo, COLS);
        rng_c1 = tile_of(x_hi, COLS);
        rng_r0 = ROW_W'(tile_of(y_lo, ROWS));
        rng_r1 = ROW_W'(tile_of(y_hi, ROWS));
    end

    // Iterator bookkeeping: last tile of the range and the row-major successor.
    logic             at_last;
    logic             is_token;
    logic [ROW_W-1:0] adv_row;
    logic [COL_W-1:0] adv_col;

    always_comb begin
        at_last  = (row_q == r1_q) && (col_q == c1_q);
        is_token = (background[row_q][col_q] == 8'(TKN));
        adv_row  = row_q;
        adv_col  = col_q + COL_W'(1);
        if (col_q == c1_q) begin
            adv_row = row_q + ROW_W'(1);
            adv_col = c0_q;
        end
    end

    // Score increment policy at 16'hFFFF.
    logic [SCORE_W-1:0] score_inc;

    always_comb begin
`ifdef MARIO_TOKEN_SCORE_SATURATE_EN
        score_inc = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
`else
        score_inc = score_q + SCORE_W'(1);
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_q;
        row_n     = row_q;
        col_n     = col_q;
        c0_n      = c0_q;
        c1_n      = c1_q;
        r1_n      = r1_q;
        wr_row_n  = wr_row_q;
        wr_col_n  = wr_col_q;
        collect_n = 1'b0;
        score_n   = score_q;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    row_n   = rng_r0;
                    col_n   = rng_c0;
                    c0_n    = rng_c0;
                    c1_n    = rng_c1;
                    r1_n    = rng_r1;
                    state_n = SCAN;
                end
            end

            SCAN: begin
                if (is_token) begin
                    wr_row_n = row_q;
                    wr_col_n = col_q;
                    state_n  = WRITE;
                end else if (at_last) begin
                    state_n = DONE;
                end else begin
                    row_n = adv_row;
                    col_n = adv_col;
                end
            end

            WRITE: begin
                if (wr.wr_ready) begin
                    collect_n = 1'b1;
                    score_n   = score_inc;
                    if (at_last) begin
                        state_n = DONE;
                    end else begin
                        row_n   = adv_row;
                        col_n   = adv_col;
                        state_n = SCAN;
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; valid/busy are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            c0_q       <= '0;
            c1_q       <= '0;
            r1_q       <= '0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= 8'(SKY);
            busy_q     <= 1'b0;
            collect_q  <= 1'b0;
            score_q    <= '0;
        end else begin
            state_q    <= state_n;
            row_q      <= row_n;
            col_q      <= col_n;
            c0_q       <= c0_n;
            c1_q       <= c1_n;
            r1_q       <= r1_n;
            wr_row_q   <= wr_row_n;
            wr_col_q   <= wr_col_n;
            wr_valid_q <= (state_n == WRITE);
            wr_data_q  <= 8'(SKY);
            busy_q     <= (state_n != IDLE);
            collect_q  <= collect_n;
            score_q    <= score_n;
        end
    end

    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_row   = wr_row_q;
    assign wr.wr_col   = wr_col_q;
    assign wr.wr_data  = wr_data_q;
    assign busy        = busy_q;
    assign collect     = collect_q;
    assign score       = score_q;

endmodule

// File: tb/tb_mario_token_collector.sv
// ----------------------------------------------------------------------------
// tb_mario_token_collector
// Scoreboard bench: stimulus pushes hand-computed writes, scores and end
// cycles into queues; a monitor pops and compares as the DUT presents them.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mario_token_collector;

    typedef struct packed {
        logic [3:0] r;
        logic [4:0] c;
    } wr_t;

    logic                   vga_clock = 1'b0;
    logic                   reset;
    logic                   tick;
    logic signed [31:0]     mario_x;
    logic signed [31:0]     mario_y;
    logic [11:0][16:0][7:0] bg;
    logic                   busy;
    logic                   collect;
    logic [15:0]            score;

    mario_token_collector_if wr_if();

    mario_token_collector dut (
        .vga_clock  (vga_clock),
        .reset      (reset),
        .tick       (tick),
        .mario_x    (mario_x),
        .mario_y    (mario_y),
        .background (bg),
        .wr         (wr_if),
        .busy       (busy),
        .collect    (collect),
        .score      (score)
    );

    always #5 vga_clock = ~vga_clock;

    int cyc = 0;
    always @(posedge vga_clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int stall_left = 0;

    wr_t         exp_wr[$];
    logic [15:0] exp_score[$];
    int          exp_end[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Store-side ready: low for stall_left cycles of a pending write.
    initial begin
        wr_if.wr_ready = 1'b1;
        forever begin
            @(negedge vga_clock);
            if (wr_if.wr_valid && stall_left > 0) begin
                wr_if.wr_ready = 1'b0;
                stall_left--;
            end else begin
                wr_if.wr_ready = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        logic       prev_busy;
        logic       prev_stall;
        logic [3:0] held_r;
        logic [4:0] held_c;
        wr_t        e;
        prev_busy  = 1'b0;
        prev_stall = 1'b0;
        held_r     = '0;
        held_c     = '0;
        forever begin
            @(negedge vga_clock);
            #1;
            if (!reset) begin
                if (prev_stall && wr_if.wr_valid)
                    check("held_addr", {23'd0, wr_if.wr_row, wr_if.wr_col}, {23'd0, held_r, held_c});
                if (wr_if.wr_valid && wr_if.wr_ready) begin
                    if (exp_wr.size() == 0) begin
                        check("write_unexpected", {15'd0, wr_if.wr_row, wr_if.wr_col, wr_if.wr_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_wr.pop_front();
                        check("write", {15'd0, wr_if.wr_row, wr_if.wr_col, wr_if.wr_data},
                              {15'd0, e.r, e.c, 8'd1});
                    end
                end
                if (collect) begin
                    if (exp_score.size() == 0) check("collect_unexpected", {16'd0, score}, 32'hFFFF_FFFF);
                    else check("score", {16'd0, score}, {16'd0, exp_score.pop_front()});
                end
            end
            if (prev_busy && !busy) begin
                if (exp_end.size() == 0) check("done_unexpected", cyc, 32'hFFFF_FFFF);
                else check("end_cycle", cyc, exp_end.pop_front());
            end
            prev_stall = wr_if.wr_valid && !wr_if.wr_ready && !reset;
            held_r     = wr_if.wr_row;
            held_c     = wr_if.wr_col;
            prev_busy  = busy;
        end
    end

    task automatic clear_bg();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 17; c++)
                bg[r][c] = 8'd1;
    endtask

    task automatic do_tick(input int x, input int y, output int k);
        @(negedge vga_clock);
        mario_x = x;
        mario_y = y;
        tick    = 1'b1;
        k       = cyc;
        @(negedge vga_clock);
        tick = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge vga_clock);
            #2;
            if (!busy) break;
        end
        if (i == 60) check("idle_timeout", 32'd1, 32'd0);
        @(negedge vga_clock);
    endtask

    task automatic push_wr(input int r, input int c, input int s);
        exp_wr.push_back('{r: 4'(r), c: 5'(c)});
        exp_score.push_back(16'(s));
    endtask

    initial begin
        int k;
        reset   = 1'b1;
        tick    = 1'b0;
        mario_x = 0;
        mario_y = 0;
        clear_bg();
        repeat (3) @(negedge vga_clock);
        reset = 1'b0;
        #2;
        check("rst_wr_valid", {31'd0, wr_if.wr_valid}, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_collect",  {31'd0, collect}, 32'd0);
        check("rst_score",    {16'd0, score}, 32'd0);
        check("rst_addr",     {23'd0, wr_if.wr_row, wr_if.wr_col}, 32'd0);
        check("rst_data",     {24'd0, wr_if.wr_data}, 32'd1);

        // Reset mid-WRITE: tiles (0,0),(0,1); WRITE from T+3, reset seen at T+4
        bg[0][1]   = 8'd4;
        stall_left = 100;
        do_tick(0, 0, k);
        @(negedge vga_clock);
        @(negedge vga_clock);
        #2;
        check("pre_rst_valid", {31'd0, wr_if.wr_valid}, 32'd1);
        reset = 1'b1;
        exp_end.push_back(k + 4);
        @(negedge vga_clock);
        #2;
        check("mid_rst_valid", {31'd0, wr_if.wr_valid}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        check("mid_rst_score", {16'd0, score}, 32'd0);
        reset      = 1'b0;
        stall_left = 0;
        clear_bg();
        repeat (3) @(negedge vga_clock);

        // Single token: x=120,y=90 -> rows 2..3, cols 3..4
        bg[2][3] = 8'd4;
        push_wr(2, 3, 1);
        do_tick(120, 90, k);
        exp_end.push_back(k + 7);
        wait_idle();

        // Backpressure: 4 stall cycles
        bg[2][3]   = 8'd4;
        stall_left = 4;
        push_wr(2, 3, 2);
        do_tick(120, 90, k);
        exp_end.push_back(k + 11);
        wait_idle();
        clear_bg();

        // Clamp: x=-10,y=470 -> single tile (11,0)
        bg[11][0] = 8'd4;
        push_wr(11, 0, 3);
        do_tick(-10, 470, k);
        exp_end.push_back(k + 4);
        wait_idle();

        // Clamp: x=660,y=470 -> single tile (11,16)
        bg[11][16] = 8'd4;
        push_wr(11, 16, 4);
        do_tick(660, 470, k);
        exp_end.push_back(k + 4);
        wait_idle();
        clear_bg();

        // Worst case: x=79,y=41 -> rows 1..2, cols 1..3, all tokens
        for (int r = 1; r <= 2; r++)
            for (int c = 1; c <= 3; c++) begin
                bg[r][c] = 8'd4;
                push_wr(r, c, 5 + (r - 1) * 3 + (c - 1));
            end
        do_tick(79, 41, k);
        exp_end.push_back(k + 14);
        wait_idle();
        clear_bg();

        // Tick while busy plus a move mid-scan: ignored, range unchanged
        bg[3][4] = 8'd4;
        bg[0][15] = 8'd4;
        push_wr(3, 4, 11);
        do_tick(120, 90, k);
        exp_end.push_back(k + 7);
        @(negedge vga_clock);
        tick    = 1'b1;
        mario_x = 600;
        mario_y = 0;
        @(negedge vga_clock);
        tick = 1'b0;
        wait_idle();
        repeat (3) @(negedge vga_clock);
        #2;
        check("no_requeue_busy", {31'd0, busy}, 32'd0);
        clear_bg();

        // Score at 16'hFFFF then one more token
        @(negedge vga_clock);
        force dut.score_q = 16'hFFFF;
        @(negedge vga_clock);
        release dut.score_q;
        bg[0][0] = 8'd4;
`ifdef MARIO_TOKEN_SCORE_SATURATE_EN
        push_wr(0, 0, 16'hFFFF);
`else
        push_wr(0, 0, 0);
`endif
        do_tick(0, 0, k);
        exp_end.push_back(k + 5);
        wait_idle();

        repeat (3) @(negedge vga_clock);
        check("wr_queue_empty",    exp_wr.size(), 32'd0);
        check("score_queue_empty", exp_score.size(), 32'd0);
        check("end_queue_empty",   exp_end.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
